riscv_multicycle_seq: RTL and testbench
=======================================

Name: riscv_multicycle_seq

Overview:
Multi-cycle sequencer for the RISC-V core. A single shared instruction/data memory bus with a req/ack handshake replaces the separate single-cycle instruction and data ports. Owns the PC, instruction and load-data registers, and the register-write strobe. The existing decode/ALU/branch datapath stays combinational and is driven from `instr` and `instr_addr`.

Parameters:
- XLEN, 32, data width of bus and load/store data.
- ADDR_W, 32, width of PC and bus address.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT_CYCLES, 255, bus wait limit (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req=1.
- bus_addr  out  ADDR_W  transaction address.
- bus_wdata  out  XLEN  write data.
- bus_ack  in  1  transaction complete; bus_rdata valid in the same cycle.
- bus_rdata  in  XLEN  read data.
- instr  out  32  latched instruction, fed to decode.
- instr_addr  out  ADDR_W  current PC.
- next_pc  in  ADDR_W  from branch unit.
- data_addr  in  ADDR_W  load/store address, equal to the ALU result.
- mem_write_data  in  XLEN  store data (rs2).
- should_read_mem  in  1  decoded load.
- should_write_mem  in  1  decoded store.
- should_write_reg  in  1  decoded register write.
- mem_read_data  out  XLEN  latched load data, to the register write mux.
- reg_write_en  out  1  one-cycle register-file write strobe.
- halt  in  1  hold before the next fetch.
- instret  out  CNT_W  retired-instruction count.
- fault  out  1  sticky bus-timeout flag; tied 0 without the optional feature.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=FETCH, instr_addr=RESET_PC, instr=32'h00000013 (NOP).
  - mem_read_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, reg_write_en=0, instr_addr holds RESET_PC, instret=0, fault=0.
  - Reset mid-transaction drops bus_req immediately; the transaction is abandoned.
- All outputs are registered.
- **States:** FETCH, EXEC, MEM, WB, HOLD, FAULT.
- **FETCH:**
  - Drive bus_req=1, bus_we=0, bus_addr=instr_addr.
  - On bus_ack=1: instr<=bus_rdata, bus_req<=0, go to EXEC.
- **EXEC (1 cycle):** the datapath settles.
  - If should_write_mem or should_read_mem: go to MEM. Load bus_addr<=data_addr and bus_we<=should_write_mem (write wins if both are set). Load bus_wdata<=mem_write_data.
  - Otherwise go to WB.
- **MEM:**
  - Hold bus_req=1 with addr/we/wdata stable until bus_ack.
  - On ack: if read, mem_read_data<=bus_rdata. Then bus_req<=0 and go to WB.
- **WB (1 cycle):**
  - reg_write_en=should_write_reg for this cycle only.
  - instr_addr<=next_pc, instret<=instret+1 (wraps modulo 2^CNT_W).
  - If halt=1, go to HOLD; else go to FETCH.
- **HOLD:** idle with bus_req=0; go to FETCH in the cycle after halt=0.
- **Handshake rules:**
  - Request fields must not change while bus_req=1 and bus_ack=0.
  - bus_ack while bus_req=0 is ignored.
  - bus_req deasserts in the cycle after ack.
  - A new request may start no earlier than the next state.
- **Latency with immediate ack:**
  - ALU/branch instruction: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles.
  - Each extra wait cycle adds 1.
- **Branches:** resolved purely through next_pc at WB; no speculation.

Optional Feature:
RISCV_SEQ_BUS_TIMEOUT_EN.
- **Defined:**
  - A wait counter clears when bus_req rises and increments each cycle with bus_req=1 and bus_ack=0.
  - When it reaches TIMEOUT_CYCLES: bus_req<=0, fault<=1, state<=FAULT.
  - FAULT is absorbing until reset; no reg_write_en, no instret increment.
  - An ack arriving in the same cycle as the limit takes priority; no fault.
- **Undefined:** no counter, waits indefinitely, fault is constant 0, FAULT is unreachable.

Decomposition:
- **Package riscv_seq_pkg:**
  - state encoding (3-bit, 6 states).
  - NOP_INSTR = 32'h00000013.
  - default parameter constants.
- **Sub-module riscv_bus_port:**
  - request/hold/ack register logic plus the timeout counter.
  - driven by the main FSM with start, we, addr, wdata.
  - returns done and timed_out.

Test Plan:
- **Reset then ALU instruction:** release reset, ack on the first FETCH cycle with rdata=addi encoding, should_write_reg=1, next_pc=4. Expect:
  - bus_addr=0 in the FETCH cycle.
  - reg_write_en pulses once at cycle 3.
  - instr_addr=4 and instret=1.
- **Load with 2 wait cycles:** data_addr=0x100, ack on the third MEM cycle with rdata=0xDEADBEEF. Expect:
  - bus_addr=0x100 stable for 3 cycles.
  - mem_read_data=0xDEADBEEF.
  - reg_write_en at cycle 6.
- **Store:** should_write_mem=1, mem_write_data=0x12345678. Expect:
  - bus_we=1, bus_wdata=0x12345678.
  - reg_write_en=0 throughout; instret increments.
- **Halt:** halt=1 at WB, held 5 cycles. Expect:
  - bus_req=0 for 5 cycles.
  - FETCH of next_pc starts 1 cycle after halt falls.
- **Reset mid-MEM:** assert reset=0 while bus_req=1. Expect:
  - bus_req=0 with no clock edge.
  - instr_addr=RESET_PC and instret=0 after release.
- **Timeout (feature on, TIMEOUT_CYCLES=4):** never ack. Expect:
  - bus_req falls after 4 cycles and fault=1 latches.
  - A later ack is ignored; fault is cleared only by reset.

Source files
------------

// File: rtl/riscv_seq_pkg.sv
// rtl/riscv_seq_pkg.sv - shared types and constants for the multi-cycle sequencer
// State encoding, the NOP word loaded on reset and default parameter values.
package riscv_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FAULT = 3'd5
  } seq_state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h00000013;
  localparam int          XLEN_DEF       = 32;
  localparam int          ADDR_W_DEF     = 32;
  localparam int          CNT_W_DEF      = 32;
  localparam int          TIMEOUT_DEF    = 255;

endpackage

// File: rtl/riscv_multicycle_seq_if.sv
// rtl/riscv_multicycle_seq_if.sv - shared instruction/data memory bus with req/ack handshake
// The master (sequencer) owns the request fields; the slave (memory) answers with ack/rdata.
interface riscv_multicycle_seq_if
  import riscv_seq_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/riscv_bus_port.sv
// rtl/riscv_bus_port.sv - request register and ack/timeout detection for the shared bus
// Wait-limit watchdog is compiled in with RISCV_SEQ_BUS_TIMEOUT_EN.
module riscv_bus_port
  import riscv_seq_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 wdata_en,
  input  logic [XLEN-1:0]      wdata,
  output logic                 done,
  output logic                 timed_out,
  riscv_multicycle_seq_if.master bus
);

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  assign done = req_q & bus.bus_ack;

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start) begin
      req_d  = 1'b1;
      we_d   = we;
      addr_d = addr;
      if (wdata_en) wdata_d = wdata;
    end else if (done || timed_out) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_q, wait_d;

  // Limit is hit on the cycle the count would reach TIMEOUT_CYCLES; a same-cycle ack wins.
  assign timed_out = req_q & ~bus.bus_ack & (wait_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = wait_q;
    if (start) wait_d = '0;
    else if (req_q && !bus.bus_ack) wait_d = wait_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  // Without the watchdog the limit parameter is inert.
  assign timed_out = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: rtl/riscv_multicycle_seq.sv
// rtl/riscv_multicycle_seq.sv - multi-cycle FETCH/EXEC/MEM/WB sequencer over one shared bus
// Bus-timeout fault is compiled in with RISCV_SEQ_BUS_TIMEOUT_EN; otherwise fault is 0.
module riscv_multicycle_seq
  import riscv_seq_pkg::*;
#(
  parameter int                XLEN           = XLEN_DEF,
  parameter int                ADDR_W         = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                CNT_W          = CNT_W_DEF,
  parameter int                TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_multicycle_seq_if.master bus,
  output logic [31:0]          instr,
  output logic [ADDR_W-1:0]    instr_addr,
  input  logic [ADDR_W-1:0]    next_pc,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic [XLEN-1:0]      mem_write_data,
  input  logic                 should_read_mem,
  input  logic                 should_write_mem,
  input  logic                 should_write_reg,
  output logic [XLEN-1:0]      mem_read_data,
  output logic                 reg_write_en,
  input  logic                 halt,
  output logic [CNT_W-1:0]     instret,
  output logic                 fault
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              rwe_q, rwe_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic              bp_start, bp_we, bp_wdata_en, bp_done, bp_timed_out;
  logic [ADDR_W-1:0] bp_addr;

  riscv_bus_port #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_port (
    .clk(clk), .reset(reset),
    .start(bp_start), .we(bp_we), .addr(bp_addr),
    .wdata_en(bp_wdata_en), .wdata(mem_write_data),
    .done(bp_done), .timed_out(bp_timed_out),
    .bus(bus)
  );

`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
  logic fault_q, fault_d;
`endif

  // Requests are launched on the edge that enters FETCH/MEM so the bus sees them immediately.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    rwe_d       = 1'b0;
    instret_d   = instret_q;
    bp_start    = 1'b0;
    bp_we       = 1'b0;
    bp_addr     = pc_q;
    bp_wdata_en = 1'b0;
`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
    fault_d     = fault_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (!bus.bus_req) begin
          bp_start = 1'b1;
        end else if (bp_done) begin
          instr_d = bus.bus_rdata[31:0];
          state_d = ST_EXEC;
        end else if (bp_timed_out) begin
          state_d = ST_FAULT;
`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
          fault_d = 1'b1;
`endif
        end
      end
      ST_EXEC: begin
        if (should_write_mem || should_read_mem) begin
          bp_start    = 1'b1;
          bp_we       = should_write_mem;
          bp_addr     = data_addr;
          bp_wdata_en = 1'b1;
          state_d     = ST_MEM;
        end else begin
          rwe_d   = should_write_reg;
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bp_done) begin
          if (!bus.bus_we) rdata_d = bus.bus_rdata;
          rwe_d   = should_write_reg;
          state_d = ST_WB;
        end else if (bp_timed_out) begin
          state_d = ST_FAULT;
`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
          fault_d = 1'b1;
`endif
        end
      end
      ST_WB: begin
        pc_d      = next_pc;
        instret_d = instret_q + CNT_W'(1);
        if (halt) begin
          state_d = ST_HOLD;
        end else begin
          bp_start = 1'b1;
          bp_addr  = next_pc;
          state_d  = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (!halt) begin
          bp_start = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FAULT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      rdata_q   <= '0;
      rwe_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      rwe_q     <= rwe_d;
      instret_q <= instret_d;
    end
  end

`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign instr         = instr_q;
  assign instr_addr    = pc_q;
  assign mem_read_data = rdata_q;
  assign reg_write_en  = rwe_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_riscv_multicycle_seq.sv
// tb/tb_riscv_multicycle_seq.sv - self-checking bench for riscv_multicycle_seq
// Instruction-level reference model; bench acts as the memory with random wait states.
module tb_riscv_multicycle_seq;
  import riscv_seq_pkg::*;

  localparam int          XLEN   = 32;
  localparam int          ADDR_W = 32;
  localparam int          CNT_W  = 32;
  localparam int          TMO    = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
  localparam int MAXW = TMO - 1;
`else
  localparam int MAXW = 6;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_addr;
  logic [ADDR_W-1:0] next_pc = '0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [XLEN-1:0]   mem_write_data = '0;
  logic              should_read_mem = 1'b0;
  logic              should_write_mem = 1'b0;
  logic              should_write_reg = 1'b0;
  logic [XLEN-1:0]   mem_read_data;
  logic              reg_write_en;
  logic              halt = 1'b0;
  logic [CNT_W-1:0]  instret;
  logic              fault;

  riscv_multicycle_seq_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  riscv_multicycle_seq #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(RST_PC), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .instr(instr), .instr_addr(instr_addr), .next_pc(next_pc),
    .data_addr(data_addr), .mem_write_data(mem_write_data),
    .should_read_mem(should_read_mem), .should_write_mem(should_write_mem),
    .should_write_reg(should_write_reg), .mem_read_data(mem_read_data),
    .reg_write_en(reg_write_en), .halt(halt), .instret(instret), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [ADDR_W-1:0] m_pc;
  logic [CNT_W-1:0]  m_instret;
  logic [XLEN-1:0]   m_rdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_instret = '0;
    m_rdata = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    model_reset();
  endtask

  // Entered at the sample point of the first FETCH cycle (bus_req expected high).
  // kind: 0 alu, 1 load, 2 store, 3 load+store flags (store wins).
  task automatic run_instr(input logic [31:0] w, input int kind, input logic wr,
                           input logic [31:0] daddr, input logic [31:0] wdat,
                           input logic [31:0] rdat, input int wf, input int wm,
                           input int hold, input logic [31:0] npc, input string tag);
    int lat;
    logic exp_we;
    exp_we = (kind >= 2);
    should_read_mem  = (kind == 1 || kind == 3);
    should_write_mem = (kind >= 2);
    should_write_reg = wr;
    data_addr = daddr;
    mem_write_data = wdat;
    next_pc = npc;
    lat = 1;
    checks++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== m_pc || bus.bus_we !== 1'b0) begin
      failures++;
      $display("FAIL %s fetch_req: req=%b addr=%h we=%b, required req=1 addr=%h we=0",
               tag, bus.bus_req, bus.bus_addr, bus.bus_we, m_pc);
    end
    for (int k = 0; k < wf; k++) begin
      bus.bus_ack = 1'b0;
      step(); lat++;
      checks++;
      if (bus.bus_req !== 1'b1 || bus.bus_addr !== m_pc || reg_write_en !== 1'b0) begin
        failures++;
        $display("FAIL %s fetch_wait: req=%b addr=%h rwe=%b, required 1/%h/0",
                 tag, bus.bus_req, bus.bus_addr, reg_write_en, m_pc);
      end
    end
    bus.bus_ack = 1'b1; bus.bus_rdata = w;
    step(); lat++;
    bus.bus_ack = 1'b0; bus.bus_rdata = $urandom;
    checks++;
    if (instr !== w || bus.bus_req !== 1'b0 || reg_write_en !== 1'b0) begin
      failures++;
      $display("FAIL %s exec: instr=%h req=%b rwe=%b, required %h/0/0",
               tag, instr, bus.bus_req, reg_write_en, w);
    end
    step(); lat++;
    if (kind != 0) begin
      for (int k = 0; k <= wm; k++) begin
        checks++;
        if (bus.bus_req !== 1'b1 || bus.bus_addr !== daddr || bus.bus_we !== exp_we ||
            bus.bus_wdata !== wdat || reg_write_en !== 1'b0) begin
          failures++;
          $display("FAIL %s mem_req: req=%b addr=%h we=%b wdata=%h, required 1/%h/%b/%h",
                   tag, bus.bus_req, bus.bus_addr, bus.bus_we, bus.bus_wdata, daddr, exp_we, wdat);
        end
        bus.bus_ack = (k == wm);
        bus.bus_rdata = rdat;
        step(); lat++;
      end
      bus.bus_ack = 1'b0;
      if (!exp_we) m_rdata = rdat;
    end
    checks++;
    if (reg_write_en !== wr || bus.bus_req !== 1'b0 || mem_read_data !== m_rdata ||
        lat !== 3 + wf + ((kind != 0) ? 1 + wm : 0)) begin
      failures++;
      $display("FAIL %s wb: rwe=%b req=%b rdata=%h cycle=%0d, required %b/0/%h/%0d",
               tag, reg_write_en, bus.bus_req, mem_read_data, lat, wr, m_rdata,
               3 + wf + ((kind != 0) ? 1 + wm : 0));
    end
    halt = (hold > 0);
    m_pc = npc;
    m_instret = m_instret + 1;
    step();
    checks++;
    if (instr_addr !== m_pc || instret !== m_instret || reg_write_en !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL %s retire: pc=%h instret=%0d rwe=%b fault=%b, required %h/%0d/0/0",
               tag, instr_addr, instret, reg_write_en, fault, m_pc, m_instret);
    end
    if (hold > 0) begin
      for (int k = 1; k < hold; k++) begin
        bus.bus_ack = $urandom_range(0, 1); bus.bus_rdata = $urandom;
        checks++;
        if (bus.bus_req !== 1'b0) begin
          failures++;
          $display("FAIL %s hold: req=%b, required 0", tag, bus.bus_req);
        end
        step();
      end
      bus.bus_ack = 1'b0;
      halt = 1'b0;
      checks++;
      if (bus.bus_req !== 1'b0 || instr !== w) begin
        failures++;
        $display("FAIL %s hold_end: req=%b instr=%h, required 0/%h", tag, bus.bus_req, instr, w);
      end
      step();
    end
  endtask

  task automatic test_reset();
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.bus_req !== 1'b0 || bus.bus_we !== 1'b0 || bus.bus_addr !== '0 || bus.bus_wdata !== '0 ||
        instr !== 32'h00000013 || instr_addr !== RST_PC || mem_read_data !== '0 ||
        reg_write_en !== 1'b0 || instret !== '0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h instr=%h pc=%h rdata=%h rwe=%b instret=%0d fault=%b",
               bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_wdata, instr, instr_addr,
               mem_read_data, reg_write_en, instret, fault);
    end
    release_reset();
  endtask

  task automatic test_alu();
    run_instr(32'h00500093, 0, 1'b1, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h4, "alu");
  endtask

  task automatic test_load_wait();
    run_instr(32'h10002083, 1, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h8, "load_wait");
  endtask

  task automatic test_store();
    run_instr(32'h00112023, 2, 1'b0, 32'h200, 32'h12345678, 32'hCAFEF00D, 1, 0, 0, 32'hC, "store");
  endtask

  task automatic test_halt();
    run_instr(32'h00000013, 0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 5, 32'h40, "halt");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_instr($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom, $urandom_range(0, MAXW), $urandom_range(0, MAXW),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    should_read_mem = 1'b1; should_write_mem = 1'b0; should_write_reg = 1'b1;
    data_addr = 32'h300; next_pc = 32'h44;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h00302083;
    step();
    bus.bus_ack = 1'b0;
    step();
    checks++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== 32'h300) begin
      failures++;
      $display("FAIL mid_mem_setup: req=%b addr=%h, required 1/00000300", bus.bus_req, bus.bus_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.bus_req !== 1'b0 || instr_addr !== RST_PC || instret !== '0 || instr !== 32'h00000013) begin
      failures++;
      $display("FAIL mid_mem_async: req=%b pc=%h instret=%0d instr=%h, required 0/%h/0/00000013",
               bus.bus_req, instr_addr, instret, instr, RST_PC);
    end
    release_reset();
    run_instr(32'h00000093, 0, 1'b1, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h4, "after_reset");
  endtask

`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
  task automatic test_timeout();
    bus.bus_ack = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      checks++;
      if (bus.bus_req !== 1'b1 || fault !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait%0d: req=%b fault=%b, required 1/0", k, bus.bus_req, fault);
      end
      step();
    end
    checks++;
    if (bus.bus_req !== 1'b0 || fault !== 1'b1) begin
      failures++;
      $display("FAIL timeout_hit: req=%b fault=%b, required 0/1", bus.bus_req, fault);
    end
    for (int k = 0; k < 5; k++) begin
      bus.bus_ack = 1'b1; bus.bus_rdata = $urandom;
      step();
      checks++;
      if (bus.bus_req !== 1'b0 || fault !== 1'b1 || instret !== m_instret ||
          reg_write_en !== 1'b0 || instr_addr !== m_pc) begin
        failures++;
        $display("FAIL fault_sticky: req=%b fault=%b instret=%0d rwe=%b pc=%h, required 0/1/%0d/0/%h",
                 bus.bus_req, fault, instret, reg_write_en, instr_addr, m_instret, m_pc);
      end
    end
    bus.bus_ack = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: fault=%b, required 0", fault);
    end
    release_reset();
    run_instr(32'h00000013, 1, 1'b1, 32'h80, 32'h0, 32'h55AA55AA, TMO - 1, TMO - 1, 0, 32'h4, "ack_at_limit");
  endtask
`else
  task automatic test_long_wait();
    run_instr(32'h00000013, 1, 1'b1, 32'h80, 32'h0, 32'h55AA55AA, 10, 12, 0, 32'h50, "long_wait");
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_halt();
    test_random();
    test_reset_mid_mem();
`ifdef RISCV_SEQ_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
